// File: rtl/avalon_burst_splitter.sv
// avalon_burst_splitter
//
// Splits Avalon-MM burst transactions into a stream of single-beat accesses
// with incrementing byte addresses, for a downstream bridge that only accepts
// burstcount = 1. Read data and read-valid are forwarded combinationally so
// the bridge's own read latency is preserved.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   avs_*_i / avs_*_o        upstream burst-capable slave side
//   avm_*_o / avm_*_i        downstream single-beat master side (to bridge)
//
// Parameters:
//   DW  data width in bits (power of two, >= 8)
//   AW  byte-address width in bits

module avalon_burst_splitter #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [AW-1:0]     avs_address_i,
    input  logic [DW/8-1:0]   avs_byteenable_i,
    input  logic              avs_read_i,
    input  logic              avs_write_i,
    input  logic [DW-1:0]     avs_writedata_i,
    input  logic [7:0]        avs_burstcount_i,
    output logic [DW-1:0]     avs_readdata_o,
    output logic              avs_waitrequest_o,
    output logic              avs_readdatavalid_o,

    output logic [AW-1:0]     avm_address_o,
    output logic [DW/8-1:0]   avm_byteenable_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    output logic [DW-1:0]     avm_writedata_o,
    output logic [7:0]        avm_burstcount_o,
    input  logic [DW-1:0]     avm_readdata_i,
    input  logic              avm_waitrequest_i,
    input  logic              avm_readdatavalid_i
);

    localparam int              BE_W   = DW / 8;
    localparam logic [AW-1:0]   STRIDE = AW'(BE_W);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [7:0]        issue_left_q, issue_left_d;
    logic [7:0]        data_left_q, data_left_d;
    logic [7:0]        beats;
    logic              rd_req;
    logic              wr_req;
    logic              wait_up;

    // A burstcount of zero is treated as a single beat.
    assign beats = (avs_burstcount_i == 8'd0) ? 8'd1 : avs_burstcount_i;

    // Read return path is a pure passthrough in every state.
    assign avs_readdata_o      = avm_readdata_i;
    assign avs_readdatavalid_o = avm_readdatavalid_i;

    assign avm_address_o    = addr_q;
    assign avm_writedata_o  = avs_writedata_i;
    assign avm_burstcount_o = 8'd1;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            be_q         <= '0;
            issue_left_q <= 8'd0;
            data_left_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            issue_left_q <= issue_left_d;
            data_left_q  <= data_left_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        be_d             = be_q;
        issue_left_d     = issue_left_q;
        data_left_d      = data_left_q;
        rd_req           = 1'b0;
        wr_req           = 1'b0;
        wait_up          = 1'b1;
        avm_byteenable_o = avs_byteenable_i;

        unique case (state_q)
            IDLE: begin
                // Reads are accepted in the decode cycle; writes are held so
                // beat 1 is forwarded from the WRITE state with its data.
                wait_up = !avs_read_i;
                if (avs_read_i) begin
                    addr_d       = avs_address_i;
                    be_d         = avs_byteenable_i;
                    issue_left_d = beats;
                    data_left_d  = beats;
                    state_d      = READ;
                end else if (avs_write_i) begin
                    addr_d       = avs_address_i;
                    issue_left_d = beats;
                    state_d      = WRITE;
                end
            end

            READ: begin
                rd_req           = (issue_left_q != 8'd0);
                avm_byteenable_o = be_q;
                if (rd_req && !avm_waitrequest_i) begin
                    addr_d       = addr_q + STRIDE;
                    issue_left_d = issue_left_q - 8'd1;
                end
                // Stay busy until every requested beat has come back.
                if (avm_readdatavalid_i && data_left_q != 8'd0) begin
                    data_left_d = data_left_q - 8'd1;
                    if (data_left_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end

            WRITE: begin
                wr_req  = avs_write_i;
                wait_up = avm_waitrequest_i;
                if (avs_write_i && !avm_waitrequest_i) begin
                    addr_d       = addr_q + STRIDE;
                    issue_left_d = issue_left_q - 8'd1;
                    if (issue_left_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Reset must silence the bridge side in the very cycle it is asserted,
    // even if the registered state is still mid-burst.
    assign avm_read_o        = rd_req && !rst;
    assign avm_write_o       = wr_req && !rst;
    assign avs_waitrequest_o = wait_up || rst;

endmodule

// File: tb/tb_avalon_burst_splitter.sv
// Directed bench for avalon_burst_splitter: a small bridge model with
// programmable wait states, a monitor logging every bridge-side transfer
// and returned read beat, and a linear sequence of checks.

module tb_avalon_burst_splitter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   avs_address_i;
    logic [3:0]      avs_byteenable_i;
    logic            avs_read_i;
    logic            avs_write_i;
    logic [DW-1:0]   avs_writedata_i;
    logic [7:0]      avs_burstcount_i;
    logic [DW-1:0]   avs_readdata_o;
    logic            avs_waitrequest_o;
    logic            avs_readdatavalid_o;
    logic [AW-1:0]   avm_address_o;
    logic [3:0]      avm_byteenable_o;
    logic            avm_read_o;
    logic            avm_write_o;
    logic [DW-1:0]   avm_writedata_o;
    logic [7:0]      avm_burstcount_o;
    logic [DW-1:0]   avm_readdata_i;
    logic            avm_waitrequest_i;
    logic            avm_readdatavalid_i;

    avalon_burst_splitter #(.DW(DW), .AW(AW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .avs_address_i       (avs_address_i),
        .avs_byteenable_i    (avs_byteenable_i),
        .avs_read_i          (avs_read_i),
        .avs_write_i         (avs_write_i),
        .avs_writedata_i     (avs_writedata_i),
        .avs_burstcount_i    (avs_burstcount_i),
        .avs_readdata_o      (avs_readdata_o),
        .avs_waitrequest_o   (avs_waitrequest_o),
        .avs_readdatavalid_o (avs_readdatavalid_o),
        .avm_address_o       (avm_address_o),
        .avm_byteenable_o    (avm_byteenable_o),
        .avm_read_o          (avm_read_o),
        .avm_write_o         (avm_write_o),
        .avm_writedata_o     (avm_writedata_o),
        .avm_burstcount_o    (avm_burstcount_o),
        .avm_readdata_i      (avm_readdata_i),
        .avm_waitrequest_i   (avm_waitrequest_i),
        .avm_readdatavalid_i (avm_readdatavalid_i)
    );

    always #5 clk = ~clk;

    // Bridge model: stalls each access for bridge_wait cycles, returns read
    // data (inverted address) one cycle after acceptance.
    int            bridge_wait = 0;
    int            wcnt        = 0;
    logic          rvalid_q    = 1'b0;
    logic [DW-1:0] rdata_q     = 32'h12345678;

    assign avm_waitrequest_i   = (wcnt != bridge_wait);
    assign avm_readdatavalid_i = rvalid_q;
    assign avm_readdata_i      = rdata_q;

    always @(posedge clk) begin
        if (avm_read_o || avm_write_o) wcnt <= avm_waitrequest_i ? wcnt + 1 : 0;
        else                           wcnt <= 0;
        rvalid_q <= avm_read_o && !avm_waitrequest_i;
        if (avm_read_o && !avm_waitrequest_i) rdata_q <= ~avm_address_o;
    end

    // Monitor, sampled mid-cycle.
    int            cyc = 0;
    int            n_rd = 0, n_wr = 0, n_vd = 0, n_both = 0, n_rdhigh = 0;
    logic [AW-1:0] rd_addr [64];
    logic [3:0]    rd_be   [64];
    int            rd_cyc  [64];
    logic [AW-1:0] wr_addr [64];
    logic [DW-1:0] wr_data [64];
    logic [3:0]    wr_be   [64];
    logic [DW-1:0] vd_data [64];
    int            vd_cyc  [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (avm_read_o && avm_write_o) n_both <= n_both + 1;
        if (avm_read_o) n_rdhigh <= n_rdhigh + 1;
        if (avm_read_o && !avm_waitrequest_i && n_rd < 64) begin
            rd_addr[n_rd] <= avm_address_o;
            rd_be[n_rd]   <= avm_byteenable_o;
            rd_cyc[n_rd]  <= cyc;
            n_rd          <= n_rd + 1;
        end
        if (avm_write_o && !avm_waitrequest_i && n_wr < 64) begin
            wr_addr[n_wr] <= avm_address_o;
            wr_data[n_wr] <= avm_writedata_o;
            wr_be[n_wr]   <= avm_byteenable_o;
            n_wr          <= n_wr + 1;
        end
        if (avs_readdatavalid_o && n_vd < 64) begin
            vd_data[n_vd] <= avs_readdata_o;
            vd_cyc[n_vd]  <= cyc;
            n_vd          <= n_vd + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Present a read command; returns the cycle in which it was accepted.
    task automatic issue_read(input logic [AW-1:0] a, input logic [7:0] bc, output int acc);
        avs_read_i       = 1'b1;
        avs_address_i    = a;
        avs_burstcount_i = bc;
        avs_byteenable_i = 4'hF;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            sample();
            if (!avs_waitrequest_o) begin
                acc = cyc;
                break;
            end
            step();
        end
        check("read_cmd_accepted", (acc >= 0), 1);
        step();
        avs_read_i = 1'b0;
    endtask

    // Called at a sample point with a write beat presented.
    task automatic wr_wait();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!avs_waitrequest_o) begin
                ok = 1'b1;
                break;
            end
            step();
            sample();
        end
        check("write_beat_accepted", ok, 1);
        step();
    endtask

    task automatic wait_vd(input int target);
        for (int i = 0; i < 300 && n_vd < target; i++) step();
        check("readvalid_count", n_vd, target);
    endtask

    initial begin
        int acc, acc1, acc2, r0, v0, w0, h0;

        rst              = 1'b1;
        avs_address_i    = '0;
        avs_byteenable_i = 4'h0;
        avs_read_i       = 1'b1;   // must be ignored during reset
        avs_write_i      = 1'b0;
        avs_writedata_i  = '0;
        avs_burstcount_i = 8'd0;

        // ---- reset state ----
        step();
        step();
        sample();
        check("rst_waitrequest", avs_waitrequest_o, 1);
        check("rst_avm_read", avm_read_o, 0);
        check("rst_avm_write", avm_write_o, 0);
        check("rst_burstcount", avm_burstcount_o, 32'd1);
        check("rst_rdata_pass", avs_readdata_o, 32'h12345678);
        check("rst_rvalid_pass", avs_readdatavalid_o, 0);
        step();
        rst        = 1'b0;
        avs_read_i = 1'b0;
        sample();
        check("idle_waitrequest", avs_waitrequest_o, 1);
        check("rst_addr_zero", avm_address_o, 32'h0);
        check("rst_no_reads", n_rd, 0);
        step();

        // ---- single read, bridge stalls 2 cycles ----
        bridge_wait = 2;
        r0 = n_rd; v0 = n_vd; h0 = n_rdhigh;
        issue_read(32'h100, 8'd1, acc);
        wait_vd(v0 + 1);
        check("t1_nreads", n_rd - r0, 1);
        check("t1_addr", rd_addr[r0], 32'h100);
        check("t1_be", rd_be[r0], 32'hF);
        check("t1_xfer_cycle", rd_cyc[r0], acc + 3);
        check("t1_read_high_cycles", n_rdhigh - h0, 3);
        check("t1_data", vd_data[v0], 32'hFFFFFEFF);

        // ---- read burst of 4 with back-to-back burstcount-0 read ----
        bridge_wait = 0;
        r0 = n_rd; v0 = n_vd;
        issue_read(32'h1000, 8'd4, acc1);
        issue_read(32'h40, 8'd0, acc2);
        wait_vd(v0 + 5);
        check("t2_first_issue", rd_cyc[r0], acc1 + 1);
        check("t2_addr0", rd_addr[r0],     32'h1000);
        check("t2_addr1", rd_addr[r0 + 1], 32'h1004);
        check("t2_addr2", rd_addr[r0 + 2], 32'h1008);
        check("t2_addr3", rd_addr[r0 + 3], 32'h100C);
        check("t2_data0", vd_data[v0],     32'hFFFFEFFF);
        check("t2_data1", vd_data[v0 + 1], 32'hFFFFEFFB);
        check("t2_data2", vd_data[v0 + 2], 32'hFFFFEFF7);
        check("t2_data3", vd_data[v0 + 3], 32'hFFFFEFF3);
        check("t2_next_accept", acc2, acc1 + 6);
        check("t2_after_last_valid", acc2, vd_cyc[v0 + 3] + 1);
        check("t3_bc0_nreads", n_rd - r0, 5);
        check("t3_bc0_addr", rd_addr[r0 + 4], 32'h40);
        check("t3_bc0_data", vd_data[v0 + 4], 32'hFFFFFFBF);

        // ---- write burst of 3 with an idle cycle between B and C ----
        bridge_wait = 1;
        w0 = n_wr;
        avs_write_i      = 1'b1;
        avs_address_i    = 32'h2000;
        avs_burstcount_i = 8'd3;
        avs_writedata_i  = 32'hA0A0A0A0;
        avs_byteenable_i = 4'hF;
        sample();
        check("wr_beat1_stalled", avs_waitrequest_o, 1);
        check("wr_cycle0_no_write", avm_write_o, 0);
        step();
        sample();
        check("wr_cycle1_write", avm_write_o, 1);
        wr_wait();
        avs_writedata_i  = 32'hB1B1B1B1;
        avs_byteenable_i = 4'h3;
        sample();
        wr_wait();
        avs_write_i = 1'b0;
        sample();
        check("wr_idle_no_write", avm_write_o, 0);
        step();
        avs_write_i      = 1'b1;
        avs_writedata_i  = 32'hC2C2C2C2;
        avs_byteenable_i = 4'hC;
        sample();
        wr_wait();
        avs_write_i = 1'b0;
        sample();
        check("wr_done_no_write", avm_write_o, 0);
        check("wr_done_addr", avm_address_o, 32'h200C);
        check("wr_count", n_wr - w0, 3);
        check("wr_addr0", wr_addr[w0],     32'h2000);
        check("wr_addr1", wr_addr[w0 + 1], 32'h2004);
        check("wr_addr2", wr_addr[w0 + 2], 32'h2008);
        check("wr_data0", wr_data[w0],     32'hA0A0A0A0);
        check("wr_data1", wr_data[w0 + 1], 32'hB1B1B1B1);
        check("wr_data2", wr_data[w0 + 2], 32'hC2C2C2C2);
        check("wr_be0", wr_be[w0],     32'hF);
        check("wr_be1", wr_be[w0 + 1], 32'h3);
        check("wr_be2", wr_be[w0 + 2], 32'hC);
        step();

        // ---- address wrap ----
        bridge_wait = 0;
        r0 = n_rd; v0 = n_vd;
        issue_read(32'hFFFFFFFC, 8'd2, acc);
        wait_vd(v0 + 2);
        check("wrap_addr0", rd_addr[r0],     32'hFFFFFFFC);
        check("wrap_addr1", rd_addr[r0 + 1], 32'h00000000);
        check("wrap_data0", vd_data[v0],     32'h00000003);
        check("wrap_data1", vd_data[v0 + 1], 32'hFFFFFFFF);
        step();

        // ---- reset after 2 of 8 beats issued ----
        r0 = n_rd; v0 = n_vd;
        issue_read(32'h3000, 8'd8, acc);
        for (int i = 0; i < 100 && n_rd < r0 + 2; i++) step();
        check("rstmid_two_issued", n_rd - r0, 2);
        rst = 1'b1;
        sample();
        check("rstmid_read_low", avm_read_o, 0);
        check("rstmid_waitrequest", avs_waitrequest_o, 1);
        step();
        rst              = 1'b0;
        avs_read_i       = 1'b1;
        avs_address_i    = 32'h500;
        avs_burstcount_i = 8'd1;
        avs_byteenable_i = 4'hF;
        sample();
        check("rstmid_idle_read_low", avm_read_o, 0);
        check("rstmid_accept_new", avs_waitrequest_o, 0);
        check("rstmid_no_more_reads", n_rd - r0, 2);
        step();
        avs_read_i = 1'b0;
        wait_vd(v0 + 3);
        check("rstmid_new_nreads", n_rd - r0, 3);
        check("rstmid_new_addr", rd_addr[r0 + 2], 32'h500);
        check("rstmid_new_data", vd_data[v0 + 2], 32'hFFFFFAFF);
        step();

        check("never_read_and_write", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
